// File: rtl/sec_timer_pkg.sv
// Shared types and defaults for the seconds timer.
// Optional build macro: SEC_TIMER_AUTO_RELOAD_EN (adds the periodic auto-reload mode).
package sec_timer_pkg;

    localparam int unsigned DEFAULT_CLK_HZ = 10000;
    localparam int unsigned DEFAULT_SEC_W  = 16;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUNNING = 2'd1,
        ST_DONE    = 2'd2
    } state_e;

endpackage : sec_timer_pkg

// File: rtl/tick_prescaler.sv
// Divides the system clock to one wrap per CLK_HZ cycles of run time.
// wrap_c is combinational so the owner can act on the edge that samples the terminal count.
module tick_prescaler
    import sec_timer_pkg::*;
#(
    parameter int unsigned CLK_HZ = DEFAULT_CLK_HZ
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic clear,
    output logic wrap_c
);

    localparam int unsigned      PRESC_W = $clog2(CLK_HZ);
    localparam logic [PRESC_W-1:0] TERM  = PRESC_W'(CLK_HZ - 1);

    logic [PRESC_W-1:0] count;

    assign wrap_c = run && (count == TERM);

    // Prescaler counter: clear beats run; frozen while run is low
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (run) begin
            count <= wrap_c ? '0 : count + PRESC_W'(1);
        end
    end

endmodule : tick_prescaler

// File: rtl/sec_timer.sv
// Loadable seconds countdown timer with start/abort/pause control.
// Optional build macro: SEC_TIMER_AUTO_RELOAD_EN (adds the periodic input and auto-reload).
module sec_timer
    import sec_timer_pkg::*;
#(
    parameter int unsigned CLK_HZ = DEFAULT_CLK_HZ,
    parameter int unsigned SEC_W  = DEFAULT_SEC_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             start,
    input  logic             abort,
    input  logic [SEC_W-1:0] secondsToCount,
`ifdef SEC_TIMER_AUTO_RELOAD_EN
    input  logic             periodic,
`endif
    output logic             finished,
    output logic             done,
    output logic             busy,
    output logic [SEC_W-1:0] remaining,
    output logic             sec_tick
);

    state_e             state_q, state_d;
    logic [SEC_W-1:0]   remaining_d;
    logic               finished_d;
    logic               sec_tick_d;
    logic               presc_clear_c;
    logic               presc_run_c;
    logic               wrap_c;
`ifdef SEC_TIMER_AUTO_RELOAD_EN
    // Only the reload path ever reads the latched load value back
    logic [SEC_W-1:0]   load_q, load_d;
    logic               periodic_q, periodic_d;
`endif

    assign presc_run_c = (state_q == ST_RUNNING) && enable;

    tick_prescaler #(
        .CLK_HZ (CLK_HZ)
    ) u_presc (
        .clk    (clk),
        .reset  (reset),
        .run    (presc_run_c),
        .clear  (presc_clear_c),
        .wrap_c (wrap_c)
    );

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            remaining  <= '0;
            finished   <= 1'b0;
            sec_tick   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
`ifdef SEC_TIMER_AUTO_RELOAD_EN
            load_q     <= '0;
            periodic_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            remaining  <= remaining_d;
            finished   <= finished_d;
            sec_tick   <= sec_tick_d;
            busy       <= (state_d == ST_RUNNING);
            done       <= (state_d == ST_DONE);
`ifdef SEC_TIMER_AUTO_RELOAD_EN
            load_q     <= load_d;
            periodic_q <= periodic_d;
`endif
        end
    end

    // Next-state and output decode; priority abort > start > tick
    always_comb begin
        state_d       = state_q;
        remaining_d   = remaining;
        finished_d    = 1'b0;
        sec_tick_d    = 1'b0;
        presc_clear_c = 1'b0;
`ifdef SEC_TIMER_AUTO_RELOAD_EN
        load_d        = load_q;
        periodic_d    = periodic_q;
`endif
        if (abort) begin
            state_d       = ST_IDLE;
            remaining_d   = '0;
            presc_clear_c = 1'b1;
        end else if (start) begin
            presc_clear_c = 1'b1;
`ifdef SEC_TIMER_AUTO_RELOAD_EN
            load_d        = secondsToCount;
            periodic_d    = periodic;
`endif
            if (secondsToCount != '0) begin
                state_d     = ST_RUNNING;
                remaining_d = secondsToCount;
            end else begin
                // A zero load expires immediately, even when periodic
                state_d     = ST_DONE;
                remaining_d = '0;
                finished_d  = 1'b1;
            end
        end else if ((state_q == ST_RUNNING) && wrap_c) begin
            sec_tick_d  = 1'b1;
            remaining_d = remaining - SEC_W'(1);
            if (remaining == SEC_W'(1)) begin
                finished_d = 1'b1;
`ifdef SEC_TIMER_AUTO_RELOAD_EN
                if (periodic_q) begin
                    // Prescaler has already wrapped to 0, so the next period starts without a gap
                    remaining_d = load_q;
                end else begin
                    state_d = ST_DONE;
                end
`else
                state_d = ST_DONE;
`endif
            end
        end
    end

endmodule : sec_timer

// File: tb/tb_sec_timer.sv
// Self-checking bench for sec_timer with CLK_HZ=4, SEC_W=8.
// The reference model tracks enabled cycles elapsed since start rather than a prescaler.
module tb_sec_timer;

    localparam int CLK_HZ = 4;
    localparam int SEC_W  = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             enable = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [SEC_W-1:0] secondsToCount = '0;
`ifdef SEC_TIMER_AUTO_RELOAD_EN
    logic             periodic = 1'b0;
`endif
    logic             finished;
    logic             done;
    logic             busy;
    logic [SEC_W-1:0] remaining;
    logic             sec_tick;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Model state: mode 0=idle 1=running 2=done
    int m_mode = 0;
    int m_n    = 0;
    int m_el   = 0;
    int m_per  = 0;
    int exp_fin = 0, exp_tick = 0, exp_rem = 0, exp_busy = 0, exp_done = 0;

    sec_timer #(
        .CLK_HZ (CLK_HZ),
        .SEC_W  (SEC_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .start          (start),
        .abort          (abort),
        .secondsToCount (secondsToCount),
`ifdef SEC_TIMER_AUTO_RELOAD_EN
        .periodic       (periodic),
`endif
        .finished       (finished),
        .done           (done),
        .busy           (busy),
        .remaining      (remaining),
        .sec_tick       (sec_tick)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d want %0d", name, $time, act, exp);
        end
    endtask

    // Reference model, evaluated on the same edges the DUT samples
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_mode = 0; m_n = 0; m_el = 0; m_per = 0;
            exp_fin = 0; exp_tick = 0;
        end else begin
            exp_fin = 0; exp_tick = 0;
            if (abort) begin
                m_mode = 0;
            end else if (start) begin
                m_n  = int'(secondsToCount);
                m_el = 0;
`ifdef SEC_TIMER_AUTO_RELOAD_EN
                m_per = int'(periodic);
`else
                m_per = 0;
`endif
                if (m_n == 0) begin
                    m_mode = 2; exp_fin = 1;
                end else begin
                    m_mode = 1;
                end
            end else if (m_mode == 1 && enable) begin
                m_el++;
                if (m_el % CLK_HZ == 0) exp_tick = 1;
                if (m_el == m_n * CLK_HZ) begin
                    exp_fin = 1;
                    if (m_per != 0) m_el = 0;
                    else m_mode = 2;
                end
            end
        end
        exp_rem  = (m_mode == 1) ? m_n - m_el / CLK_HZ : 0;
        exp_busy = (m_mode == 1) ? 1 : 0;
        exp_done = (m_mode == 2) ? 1 : 0;
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_finished",  int'(finished),  exp_fin);
            chk("model_sec_tick",  int'(sec_tick),  exp_tick);
            chk("model_remaining", int'(remaining), exp_rem);
            chk("model_busy",      int'(busy),      exp_busy);
            chk("model_done",      int'(done),      exp_done);
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Pulse start for one edge; returns half a cycle after that edge
    task automatic do_start(input int n);
        secondsToCount = SEC_W'(n);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset and one-shot N=3
        #2 reset = 1'b1;
        chk_en = 1'b1;
        wait_cyc(2);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_rem",  int'(remaining), 0);
        chk("reset_fin",  int'(finished), 0);
        reset  = 1'b0;
        enable = 1'b1;
        wait_cyc(2);
        do_start(3);
        chk("os_rem_start", int'(remaining), 3);
        chk("os_busy", int'(busy), 1);
        wait_cyc(3);
        chk("os_no_tick3", int'(sec_tick), 0);
        wait_cyc(1);
        chk("os_tick4", int'(sec_tick), 1);
        chk("os_rem_after4", int'(remaining), 2);
        wait_cyc(4);
        chk("os_tick8", int'(sec_tick), 1);
        chk("os_rem_after8", int'(remaining), 1);
        wait_cyc(3);
        chk("os_fin_before", int'(finished), 0);
        wait_cyc(1);
        chk("os_fin12", int'(finished), 1);
        chk("os_tick12", int'(sec_tick), 1);
        chk("os_rem0", int'(remaining), 0);
        wait_cyc(1);
        chk("os_fin_single", int'(finished), 0);
        chk("os_done", int'(done), 1);
        chk("os_busy_low", int'(busy), 0);
        wait_cyc(3);

        // Pause: N=2, freeze 10 cycles at prescaler=2
        do_start(2);
        wait_cyc(2);
        enable = 1'b0;
        wait_cyc(10);
        chk("pause_rem_held", int'(remaining), 2);
        chk("pause_busy", int'(busy), 1);
        enable = 1'b1;
        wait_cyc(5);
        chk("pause_fin_not_yet", int'(finished), 0);
        wait_cyc(1);
        chk("pause_fin18", int'(finished), 1);
        wait_cyc(2);

        // Zero load, then restart mid-count
        do_start(0);
        chk("zero_fin", int'(finished), 1);
        chk("zero_done", int'(done), 1);
        wait_cyc(1);
        chk("zero_fin_single", int'(finished), 0);
        chk("zero_done_hold", int'(done), 1);
        do_start(5);
        wait_cyc(12);
        chk("rs_rem2", int'(remaining), 2);
        wait_cyc(1);
        do_start(1);
        chk("rs_rem1", int'(remaining), 1);
        wait_cyc(3);
        chk("rs_fin_not_yet", int'(finished), 0);
        wait_cyc(1);
        chk("rs_fin4", int'(finished), 1);
        wait_cyc(20);
        chk("rs_idle_done", int'(done), 1);

        // Abort coinciding with the expiry tick
        do_start(1);
        wait_cyc(3);
        do_abort();
        chk("ab_fin", int'(finished), 0);
        chk("ab_busy", int'(busy), 0);
        chk("ab_done", int'(done), 0);
        chk("ab_rem", int'(remaining), 0);
        wait_cyc(6);

        // Async reset mid-cycle while running
        do_start(3);
        wait_cyc(5);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("ar_busy", int'(busy), 0);
        chk("ar_rem", int'(remaining), 0);
        chk("ar_tick", int'(sec_tick), 0);
        @(negedge clk);
        reset = 1'b0;
        wait_cyc(2);

        // Simultaneous start and abort
        do_start(4);
        wait_cyc(2);
        secondsToCount = SEC_W'(7);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("sa_busy", int'(busy), 0);
        chk("sa_rem", int'(remaining), 0);

        // Start on the tick edge: new load wins, no tick for old run
        do_start(2);
        wait_cyc(3);
        do_start(3);
        chk("st_rem", int'(remaining), 3);
        chk("st_tick", int'(sec_tick), 0);
        wait_cyc(12);
        chk("st_fin", int'(finished), 1);
        wait_cyc(2);

`ifdef SEC_TIMER_AUTO_RELOAD_EN
        // Periodic N=2: finished every 8 cycles, never done
        periodic = 1'b1;
        do_start(2);
        periodic = 1'b0;
        for (int i = 0; i < 5; i++) begin
            wait_cyc(7);
            chk("per_gap", int'(finished), 0);
            wait_cyc(1);
            chk("per_fin", int'(finished), 1);
            chk("per_done", int'(done), 0);
            chk("per_rem", int'(remaining), 2);
        end
        wait_cyc(2);
        do_abort();
        chk("per_abort_busy", int'(busy), 0);
        wait_cyc(10);
`endif

        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_sec_timer

// File: doc/sec_timer.md
Name: sec_timer

Overview:
Parametrised successor to the single-shot seconds timer used by the traffic-light FSMs.
- Divides the system clock down to 1 s ticks.
- Counts down a loaded seconds value and flags expiry.
- Adds start/abort/pause control, a remaining-time readout, a done level and a generalised clock rate and width.
- Sits between the intersection control FSM (which loads phase durations) and the light drivers.

Parameters:
CLK_HZ, 10000, clock cycles per second; prescaler terminal count is CLK_HZ-1; legal range ≥2.
SEC_W, 16, width of the seconds load value and the remaining count.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
enable  in  1  1 = count; 0 = freeze prescaler and remaining (pause). Does not block start/abort.
start  in  1  1-cycle pulse: latch secondsToCount and (re)start.
abort  in  1  1-cycle pulse: stop, go IDLE, no finished.
secondsToCount  in  SEC_W  duration in seconds; sampled only when start=1.
finished  out  1  1-cycle pulse on expiry.
done  out  1  level; high in DONE until the next start, abort or reset.
busy  out  1  high in RUNNING.
remaining  out  SEC_W  seconds left; registered.
sec_tick  out  1  1-cycle pulse at each prescaler wrap while RUNNING and enable=1.

Behaviour:
- Reset (async, any state, mid-count included): state=IDLE; prescaler, remaining and load latch = 0; finished, done, busy, sec_tick = 0.
- Derived localparam: PRESC_W = $clog2(CLK_HZ). Prescaler is unsigned, counts 0..CLK_HZ-1 and wraps to 0.
- States:
  - IDLE: outputs low. start → RUNNING, or → DONE if the load is 0.
  - RUNNING: busy=1.
  - DONE: done=1. start → RUNNING or DONE by the same rule as IDLE.
- On start at edge k with N = secondsToCount:
  - Load latch ← N.
  - If N > 0: prescaler ← 0, remaining ← N, state ← RUNNING.
  - If N = 0: state ← DONE and finished=1 from edge k+1 (one cycle).
- While RUNNING and enable=1: prescaler increments each edge. At the edge sampling prescaler==CLK_HZ-1:
  - prescaler ← 0 and sec_tick=1 for one cycle.
  - remaining ← remaining-1.
  - If remaining was 1: state ← DONE and finished=1 for one cycle.
- Latency: with enable held at 1, finished is high in the cycle after edge k + N·CLK_HZ.
- Pause: enable=0 holds prescaler and remaining. No sec_tick or finished is produced. The partial second is kept and resumes on enable=1.
- start during RUNNING restarts with the new value. The pending tick and expiry in the same cycle are discarded.
- Priority: reset > abort > start > tick.
  - abort in any state: → IDLE, remaining ← 0, no finished.
  - abort and start in the same cycle: abort wins.
- remaining never underflows; it holds 0 in DONE and IDLE.
- secondsToCount changes while RUNNING are ignored.

Optional Feature:
Macro: SEC_TIMER_AUTO_RELOAD_EN.
- Defined:
  - Adds input `periodic` (1 bit), sampled with start and latched.
  - If the latched periodic=1, expiry pulses finished, reloads remaining ← load latch and prescaler ← 0, and stays RUNNING.
  - done stays 0 in periodic mode.
  - Period = N·CLK_HZ cycles exactly, with no gap cycle.
  - N=0 with periodic=1 behaves as one-shot N=0.
- Undefined: no periodic port; one-shot behaviour only.

Decomposition:
- Package sec_timer_pkg:
  - State enum {ST_IDLE, ST_RUNNING, ST_DONE}, 2-bit encoding.
  - Default CLK_HZ constant 10000.
- Sub-module tick_prescaler:
  - Parameter CLK_HZ; inputs clk, reset, run (RUNNING & enable), clear.
  - Output wrap pulse.
- sec_timer holds the FSM, remaining and the load latch.

Test Plan:
All scenarios use CLK_HZ=4, SEC_W=8.
- Reset/one-shot: reset high then low; start with N=3, enable=1 → sec_tick at edges k+4, k+8, k+12. remaining reads 3,2,1,0. finished is a single cycle after edge k+12. done=1 and busy=0 afterwards. All outputs read 0 while reset is high.
- Pause: N=2; drop enable for 10 cycles at prescaler=2 → remaining stays 2 and prescaler is frozen. After re-enable, finished arrives exactly 10 cycles later than the un-paused run.
- Zero load and restart: N=0 → finished one cycle later and done=1. While RUNNING N=5 at remaining=2, start with N=1 → remaining=1 and finished 4 cycles later. The original count never fires.
- Abort and async reset: abort at remaining=1, prescaler=3 (coinciding with the expiry tick) → IDLE, no finished. Async reset asserted mid-cycle clears all outputs before the next edge.
- Simultaneous events: start and abort in the same cycle → IDLE. start on the tick edge → new value loaded, no sec_tick counted for the old run.
- SEC_TIMER_AUTO_RELOAD_EN build: periodic=1, N=2 → finished every 8 cycles for 5 periods, done=0 throughout. abort stops it.
